uart_tx_fifo: RTL and testbench

Parametrised next-generation UART transmitter. It accepts parallel words through a valid strobe into an internal FIFO and serialises them LSB-first. Each frame is start bit, DATA_WIDTH data bits, optional parity bit, then one or two stop bits. An internal prescaler sets the bit period. The block sits between the system/register-file side (word producer) and the TX pad, and replaces the fixed 8-bit, one-word-at-a-time transmitter.

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with parity, 1/2 stop bits and prescaler
module uart_tx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Data_VLD,
    input  logic [DATA_WIDTH-1:0]     Data,
    input  logic                      P_EN,
    input  logic                      P_type,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      full,
    output logic                      overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic                  push, pop;

    // Frame engine registers
    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_WIDTH-1:0] plast_q, plast_d;
    logic [3:0]                bit_idx_q, bit_idx_d;
    logic                      stop_idx_q, stop_idx_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      parity_q, parity_d;
    logic                      pen_q, pen_d;
    logic                      stop2_q, stop2_d;
    logic                      tx;
    logic                      load;
    logic                      bit_last;
    logic                      fifo_nempty;

    // A push while full is rejected even if a pop frees a slot in the same cycle
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign push        = Data_VLD && !full;
    assign fifo_nempty = (count_q != '0);
    assign bit_last    = (bit_cnt_q == plast_q);

    // Word storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= Data;
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
            overflow_q <= Data_VLD && full;
        end
    end

    // Frame sequencing: next state, bit timing, head-of-FIFO load and line level
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_last ? '0 : bit_cnt_q + PRESCALE_WIDTH'(1);
        plast_d    = plast_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        pen_d      = pen_q;
        stop2_d    = stop2_q;
        tx         = 1'b1;
        load       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                load      = fifo_nempty;
            end
            START: begin
                tx = 1'b0;
                if (bit_last) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d    = pen_q ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                tx = parity_q;
                if (bit_last) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_last) begin
                    if (stop_idx_q == stop2_q) begin
                        // Chain straight into the next frame when a word is waiting
                        if (fifo_nempty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame start: take the head word and freeze the line configuration
        if (load) begin
            pop        = 1'b1;
            state_d    = START;
            bit_cnt_d  = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            shift_d    = mem_q[rd_ptr_q];
            parity_d   = (^mem_q[rd_ptr_q]) ^ P_type;
            pen_d      = P_EN;
            stop2_d    = STOP2;
            plast_d    = (Prescale == '0) ? '0 : Prescale - PRESCALE_WIDTH'(1);
        end
    end

    // Frame engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            plast_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            pen_q      <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            plast_q    <= plast_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            pen_q      <= pen_d;
            stop2_q    <= stop2_d;
        end
    end

    assign TX_OUT   = tx;
    assign busy     = (state_q != IDLE) || fifo_nempty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       Data_VLD;
    logic [7:0] Data;
    logic       P_EN;
    logic       P_type;
    logic       STOP2;
    logic [7:0] Prescale;
    logic       TX_OUT;
    logic       busy;
    logic       full;
    logic       overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    logic tx_log [0:1023];

    uart_tx_fifo #(
        .DATA_WIDTH    (8),
        .FIFO_DEPTH    (4),
        .PRESCALE_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Data_VLD (Data_VLD),
        .Data     (Data),
        .P_EN     (P_EN),
        .P_type   (P_type),
        .STOP2    (STOP2),
        .Prescale (Prescale),
        .TX_OUT   (TX_OUT),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d compared, required run to finish", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst      = 1'b1;
        Data_VLD = 1'b0;
        Data     = 8'h00;
        P_EN     = 1'b0;
        P_type   = 1'b0;
        STOP2    = 1'b0;
        Prescale = 8'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (TX_OUT !== 1'b1)   begin n_err++; $display("FAIL reset_tx: got %b want 1", TX_OUT); end
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    endtask

    // 0xA5 with no parity, one stop bit; presc 0 must behave like 1
    task automatic test_basic(input logic [7:0] presc);
        logic exp_b [0:9];
        exp_b = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        Prescale = presc;
        P_EN     = 1'b0;
        STOP2    = 1'b0;
        Data     = 8'hA5;
        Data_VLD = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            tx_log[c] = TX_OUT;
            if (c == 1) begin
                Data_VLD = 1'b0;
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise p=%0d: got %b want 1", presc, busy); end
            end
            if (c == 11) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_stop p=%0d: got %b want 1", presc, busy); end
            end
            if (c == 12) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_fall p=%0d: got %b want 0", presc, busy); end
            end
        end
        n_cmp++; if (tx_log[1] !== 1'b1) begin n_err++; $display("FAIL basic_pre_start p=%0d: got %b want 1", presc, tx_log[1]); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (tx_log[2+i] !== exp_b[i]) begin
                n_err++; $display("FAIL basic_bit%0d p=%0d: got %b want %b", i, presc, tx_log[2+i], exp_b[i]);
            end
        end
        n_cmp++; if (tx_log[12] !== 1'b1) begin n_err++; $display("FAIL basic_idle p=%0d: got %b want 1", presc, tx_log[12]); end
    endtask

    task automatic test_parity();
        logic [7:0] d_tab [0:3];
        logic       t_tab [0:3];
        logic       p_tab [0:3];
        d_tab = '{8'hA5, 8'hA5, 8'h01, 8'h01};
        t_tab = '{1'b0, 1'b1, 1'b0, 1'b1};
        p_tab = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            Prescale = 8'd1;
            P_EN     = 1'b1;
            P_type   = t_tab[k];
            STOP2    = 1'b0;
            Data     = d_tab[k];
            Data_VLD = 1'b1;
            for (int c = 1; c <= 13; c++) begin
                @(negedge clk);
                tx_log[c] = TX_OUT;
                if (c == 1) Data_VLD = 1'b0;
            end
            n_cmp++; if (tx_log[2] !== 1'b0)      begin n_err++; $display("FAIL par_start%0d: got %b want 0", k, tx_log[2]); end
            n_cmp++; if (tx_log[3] !== d_tab[k][0]) begin n_err++; $display("FAIL par_d0_%0d: got %b want %b", k, tx_log[3], d_tab[k][0]); end
            n_cmp++; if (tx_log[11] !== p_tab[k]) begin n_err++; $display("FAIL par_bit%0d: got %b want %b", k, tx_log[11], p_tab[k]); end
            n_cmp++; if (tx_log[12] !== 1'b1)     begin n_err++; $display("FAIL par_stop%0d: got %b want 1", k, tx_log[12]); end
            n_cmp++; if (tx_log[13] !== 1'b1)     begin n_err++; $display("FAIL par_idle%0d: got %b want 1", k, tx_log[13]); end
        end
        P_EN   = 1'b0;
        P_type = 1'b0;
    endtask

    // Prescale 4, two stop bits, 0x00: 36 low cycles then 8 high, 44 total
    task automatic test_prescale_stop2();
        logic want;
        Prescale = 8'd4;
        STOP2    = 1'b1;
        P_EN     = 1'b0;
        Data     = 8'h00;
        Data_VLD = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            if (c == 1) Data_VLD = 1'b0;
            if (c >= 2 && c <= 45) begin
                want = (c - 2 < 36) ? 1'b0 : 1'b1;
                n_cmp++; if (TX_OUT !== want) begin n_err++; $display("FAIL ps_line c=%0d: got %b want %b", c, TX_OUT, want); end
            end
            if (c == 45) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ps_busy_last: got %b want 1", busy); end
            end
            if (c == 46) begin
                n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL ps_busy_fall: got %b want 0", busy); end
                n_cmp++; if (TX_OUT !== 1'b1) begin n_err++; $display("FAIL ps_idle: got %b want 1", TX_OUT); end
            end
        end
        STOP2 = 1'b0;
    endtask

    // Six strobes 0x11..0x66 at Prescale 16; the sixth meets a full FIFO
    task automatic test_fifo_fill();
        int         base;
        logic [7:0] rx;
        logic [7:0] want;
        Prescale = 8'd16;
        STOP2    = 1'b0;
        P_EN     = 1'b0;
        Data     = 8'h11;
        Data_VLD = 1'b1;
        for (int c = 1; c <= 802; c++) begin
            @(negedge clk);
            tx_log[c] = TX_OUT;
            case (c)
                1: Data = 8'h22;
                2: Data = 8'h33;
                3: Data = 8'h44;
                4: begin
                    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full_c4: got %b want 0", full); end
                    Data = 8'h55;
                end
                5: begin
                    n_cmp++; if (full !== 1'b1)     begin n_err++; $display("FAIL fill_full_c5: got %b want 1", full); end
                    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf_c5: got %b want 0", overflow); end
                    Data = 8'h66;
                end
                6: begin
                    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_ovf_c6: got %b want 1", overflow); end
                    Data_VLD = 1'b0;
                end
                7: begin
                    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf_c7: got %b want 0", overflow); end
                end
                161: begin
                    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full_c161: got %b want 1", full); end
                end
                162: begin
                    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full_c162: got %b want 0", full); end
                end
                801: begin
                    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fill_busy_c801: got %b want 1", busy); end
                end
                802: begin
                    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL fill_busy_c802: got %b want 0", busy); end
                    n_cmp++; if (TX_OUT !== 1'b1) begin n_err++; $display("FAIL fill_idle_c802: got %b want 1", TX_OUT); end
                end
                default: ;
            endcase
        end
        for (int k = 0; k < 5; k++) begin
            base = 2 + k * 160;
            want = 8'((k + 1) * 17);
            for (int j = 0; j < 8; j++) rx[j] = tx_log[base + 16 * (j + 1) + 8];
            n_cmp++; if (rx !== want) begin n_err++; $display("FAIL fill_word%0d: got %h want %h", k, rx, want); end
            n_cmp++; if (tx_log[base] !== 1'b0 || tx_log[base-1] !== 1'b1) begin
                n_err++; $display("FAIL fill_edge%0d: got %b%b want 10", k, tx_log[base-1], tx_log[base]);
            end
            n_cmp++; if (tx_log[base + 152] !== 1'b1) begin n_err++; $display("FAIL fill_stop%0d: got %b want 1", k, tx_log[base + 152]); end
        end
    endtask

    // P_EN flips 0->1 inside frame 1; only frame 2 carries parity
    task automatic test_mid_frame_cfg();
        logic exp_b [0:20];
        exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        Prescale = 8'd1;
        P_EN     = 1'b0;
        P_type   = 1'b0;
        STOP2    = 1'b0;
        Data     = 8'h0F;
        Data_VLD = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            tx_log[c] = TX_OUT;
            if (c == 1) Data = 8'h03;
            if (c == 2) Data_VLD = 1'b0;
            if (c == 5) P_EN = 1'b1;
            if (c == 23) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cfg_busy_fall: got %b want 0", busy); end
            end
        end
        for (int i = 0; i < 21; i++) begin
            n_cmp++;
            if (tx_log[2+i] !== exp_b[i]) begin
                n_err++; $display("FAIL cfg_bit c=%0d: got %b want %b", 2 + i, tx_log[2+i], exp_b[i]);
            end
        end
        P_EN = 1'b0;
    endtask

    // Reset lands in data bit 3 of a 0x00 frame with two words still queued
    task automatic test_reset_mid_frame();
        Prescale = 8'd2;
        P_EN     = 1'b0;
        STOP2    = 1'b0;
        Data     = 8'h00;
        Data_VLD = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) Data = 8'h12;
            if (c == 2) Data = 8'h34;
            if (c == 3) Data_VLD = 1'b0;
            if (c == 10) begin
                n_cmp++; if (TX_OUT !== 1'b0) begin n_err++; $display("FAIL rstm_pre_tx: got %b want 0", TX_OUT); end
                n_cmp++; if (busy !== 1'b1)   begin n_err++; $display("FAIL rstm_pre_busy: got %b want 1", busy); end
                rst = 1'b1;
            end
            if (c == 11) begin
                n_cmp++; if (TX_OUT !== 1'b1)   begin n_err++; $display("FAIL rstm_tx: got %b want 1", TX_OUT); end
                n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rstm_busy: got %b want 0", busy); end
                n_cmp++; if (full !== 1'b0)     begin n_err++; $display("FAIL rstm_full: got %b want 0", full); end
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstm_ovf: got %b want 0", overflow); end
                rst = 1'b0;
            end
            if (c >= 12) begin
                n_cmp++; if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                    n_err++; $display("FAIL rstm_quiet c=%0d: got tx=%b busy=%b want tx=1 busy=0", c, TX_OUT, busy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(8'd1);
        test_basic(8'd0);
        test_parity();
        test_prescale_stop2();
        test_fifo_fill();
        test_mid_frame_cfg();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
